// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, the bubble
// NOP word, reset level, reset PC and the IF state encodings.
package if_stage_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0]     ZeroWord  = 32'h0000_0000;
  localparam logic                   RstEnable = 1'b1;
  localparam logic [InstAddrBus-1:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_HOLD = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage (master)
// and instruction memory (slave).
//
// Handshake: inst_req_o is asserted with a stable inst_addr_o until the cycle
// in which inst_ack_i is high; inst_rdata_i is valid only in a cycle where
// both inst_req_o and inst_ack_i are high. Ack without req is ignored.
interface if_stage_if;
  import if_stage_pkg::*;

  logic                   inst_req_o;
  logic [InstAddrBus-1:0] inst_addr_o;
  logic                   inst_ack_i;
  logic [InstBus-1:0]     inst_rdata_i;

  modport master (
    output inst_req_o,
    output inst_addr_o,
    input  inst_ack_i,
    input  inst_rdata_i
  );

  modport slave (
    input  inst_req_o,
    input  inst_addr_o,
    output inst_ack_i,
    output inst_rdata_i
  );
endinterface

// File: rtl/if_stage_if_id.sv
// IF/ID pipeline register: load a real instruction, load a bubble (NOP with
// valid cleared, PC still tracked), or hold.
module if_stage_if_id
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   bubble,
  input  logic [InstAddrBus-1:0] pc,
  input  logic [InstBus-1:0]     inst,
  output logic [InstAddrBus-1:0] id_pc_o,
  output logic [InstBus-1:0]     id_inst_o,
  output logic                   id_valid_o
);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      id_pc_o    <= '0;
      id_inst_o  <= ZeroWord;
      id_valid_o <= 1'b0;
    end else if (load) begin
      id_pc_o    <= pc;
      id_inst_o  <= inst;
      id_valid_o <= 1'b1;
    end else if (bubble) begin
      id_pc_o    <= pc;
      id_inst_o  <= ZeroWord;
      id_valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, memory handshake FSM, delayed-branch
// redirect and IF/ID register. Optional counters under `IF_PERF_EN`.
module if_stage
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   branch_flag_i,
  input  logic [InstAddrBus-1:0] branch_target_address_i,
  if_stage_if.master             mem,
  output logic                   stallreq_o,
  output logic [InstAddrBus-1:0] id_pc_o,
  output logic [InstBus-1:0]     id_inst_o,
  output logic                   id_valid_o,
  output if_state_e              dbg_state_o
`ifdef IF_PERF_EN
  ,
  output logic [31:0]            perf_fetch_o,
  output logic [31:0]            perf_stall_o
`endif
);

  if_state_e              state_q, state_d;
  logic [InstAddrBus-1:0] pc_q, next_pc;
  logic [InstBus-1:0]     buf_q, load_inst;
  logic                   pend_valid_q;
  logic [InstAddrBus-1:0] pend_target_q;

  logic req, stallreq, advance, id_load, id_bubble, buf_load, take;

  // A branch leaves ID only when ID holds a real instruction and is not stalled.
  assign take = branch_flag_i && id_valid_o && !stall_i;

  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    stallreq  = 1'b0;
    advance   = 1'b0;
    id_load   = 1'b0;
    id_bubble = 1'b0;
    buf_load  = 1'b0;
    load_inst = buf_q;
    case (state_q)
      IF_IDLE: state_d = IF_REQ;
      IF_REQ: begin
        req = 1'b1;
        if (mem.inst_ack_i) begin
          if (!stall_i) begin
            id_load   = 1'b1;
            load_inst = mem.inst_rdata_i;
            advance   = 1'b1;
          end else begin
            buf_load = 1'b1;
            state_d  = IF_HOLD;
          end
        end else begin
          stallreq = 1'b1;
          if (!stall_i) id_bubble = 1'b1;
        end
      end
      IF_HOLD: begin
        if (!stall_i) begin
          id_load = 1'b1;
          advance = 1'b1;
          state_d = IF_REQ;
        end
      end
      default: state_d = IF_IDLE;
    endcase
  end

  // The delay slot is whatever IF is fetching at take, so the redirect lands on
  // the PC update that follows it: immediately if IF advances now, else later.
  always_comb begin
    if (take)              next_pc = branch_target_address_i;
    else if (pend_valid_q) next_pc = pend_target_q;
    else                   next_pc = pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q       <= IF_IDLE;
      pc_q          <= RESET_PC;
      buf_q         <= ZeroWord;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q <= state_d;
      if (buf_load) buf_q <= mem.inst_rdata_i;
      if (advance) begin
        pc_q         <= next_pc;
        pend_valid_q <= 1'b0;
      end else if (take) begin
        pend_valid_q  <= 1'b1;
        pend_target_q <= branch_target_address_i;
      end
    end
  end

  // Reset drops an outstanding request in the cycle it is asserted.
  assign mem.inst_req_o  = req && (rst != RstEnable);
  assign mem.inst_addr_o = pc_q;
  assign stallreq_o      = stallreq && (rst != RstEnable);
  assign dbg_state_o     = state_q;

  if_stage_if_id u_if_id (
    .clk        (clk),
    .rst        (rst),
    .load       (id_load),
    .bubble     (id_bubble),
    .pc         (pc_q),
    .inst       (load_inst),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .id_valid_o (id_valid_o)
  );

`ifdef IF_PERF_EN
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      perf_fetch_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (id_load)    perf_fetch_o <= perf_fetch_o + 32'd1;
      if (stallreq_o) perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a directed per-cycle vector table for the fetch, wait,
// branch, stall and reset scenarios, then randomized traffic against a model.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        stallreq_o, id_valid_o;
  logic [31:0] id_pc_o, id_inst_o;
  if_state_e   dbg_state;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetch, perf_stall;
`endif

  if_stage_if mem_if ();

  if_stage dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall_i                 (stall_i),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .mem                     (mem_if.master),
    .stallreq_o              (stallreq_o),
    .id_pc_o                 (id_pc_o),
    .id_inst_o               (id_inst_o),
    .id_valid_o              (id_valid_o),
    .dbg_state_o             (dbg_state)
`ifdef IF_PERF_EN
    ,
    .perf_fetch_o            (perf_fetch),
    .perf_stall_o            (perf_stall)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Directed vectors: inputs for one cycle, combinational outputs during it,
  // IF/ID contents after its rising edge. Memory data equals the fetch address.
  typedef struct {
    logic        rst, stall, ack, br;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_sreq;
    logic [31:0] e_pc, e_inst;
    logic        e_val;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic s, logic a, logic b, logic [31:0] t,
                              logic rq, logic [31:0] ad, logic sr,
                              logic [31:0] pc, logic [31:0] in, logic v);
    vec_t x;
    x.rst = r; x.stall = s; x.ack = a; x.br = b; x.tgt = t;
    x.e_req = rq; x.e_addr = ad; x.e_sreq = sr;
    x.e_pc = pc; x.e_inst = in; x.e_val = v;
    vecs.push_back(x);
  endfunction

  // zero-wait fetch of address a, optionally resolving a branch in ID
  function automatic void zw(logic [31:0] a, logic b = 1'b0, logic [31:0] t = 32'h0);
    add(0, 0, 1, b, t, 1, a, 0, a, a, 1);
  endfunction

  task automatic drive(logic r, logic s, logic a, logic b, logic [31:0] t, logic [31:0] d);
    rst = r; stall_i = s; mem_if.inst_ack_i = a; branch_flag_i = b;
    branch_target_address_i = t; mem_if.inst_rdata_i = d;
  endtask

  // Reference model state (random phase), kept in terms of words and program order.
  logic        m_started, m_held, m_pend, m_armed, m_slot, m_valid;
  logic [31:0] m_pc, m_buf, m_pt, m_id_pc, m_id_inst;
  logic [64:0] exp_q[$];

  task automatic model_reset();
    m_started = 0; m_held = 0; m_pend = 0; m_armed = 0; m_slot = 0; m_valid = 0;
    m_pc = RESET_PC; m_buf = 0; m_pt = 0; m_id_pc = 0; m_id_inst = 0;
  endtask

  initial begin
    logic        r_rst, r_stall, r_ack, r_br, e_req, take, loaded, adv;
    logic [31:0] r_tgt, r_data;
    logic [64:0] e;

    drive(1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // reset, then zero-wait fetch 0,4,8
    add(1, 0, 0, 0, 0,        0, 32'h0,   0,  32'h0, 32'h0, 0);
    add(0, 0, 0, 0, 0,        0, 32'h0,   0,  32'h0, 32'h0, 0);
    zw(32'h0); zw(32'h4);
    // ack held off 3 cycles at pc=8
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 1, 32'h8, 1, 32'h8, 32'h0, 0);
    zw(32'h8); zw(32'hC); zw(32'h10);
    // branch at 0x10 -> 0x100, zero-wait delay slot
    zw(32'h14, 1, 32'h100); zw(32'h100);
    // branch back to 0xC via 0x104, then branch at 0x10 with late delay slot
    zw(32'h104, 1, 32'hC); zw(32'hC); zw(32'h10);
    add(0, 0, 0, 1, 32'h100,  1, 32'h14,  1,  32'h14, 32'h0, 0);
    add(0, 0, 0, 1, 32'h200,  1, 32'h14,  1,  32'h14, 32'h0, 0);
    zw(32'h14); zw(32'h100);
    // stall over an ack: HOLD for two cycles, then buffered word enters ID
    add(0, 1, 1, 0, 0,        1, 32'h104, 0,  32'h100, 32'h100, 1);
    add(0, 1, 0, 0, 0,        0, 32'h104, 0,  32'h100, 32'h100, 1);
    add(0, 0, 0, 0, 0,        0, 32'h104, 0,  32'h104, 32'h104, 1);
    zw(32'h108);
    // stall with no ack, then a pending redirect wiped by reset
    add(0, 1, 0, 0, 0,        1, 32'h10C, 1,  32'h108, 32'h108, 1);
    add(0, 0, 0, 1, 32'h300,  1, 32'h10C, 1,  32'h10C, 32'h0, 0);
    add(1, 0, 0, 0, 0,        0, 32'h10C, 0,  32'h0, 32'h0, 0);
    add(0, 0, 0, 0, 0,        0, 32'h0,   0,  32'h0, 32'h0, 0);
    zw(32'h0); zw(32'h4);
    // PC wraps past 2^32
    zw(32'h8, 1, 32'hFFFF_FFFC); zw(32'hFFFF_FFFC); zw(32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].ack, vecs[i].br, vecs[i].tgt, vecs[i].e_addr);
      #1;
      chk($sformatf("v%0d inst_req", i),  32'(mem_if.inst_req_o), 32'(vecs[i].e_req));
      chk($sformatf("v%0d inst_addr", i), mem_if.inst_addr_o,     vecs[i].e_addr);
      chk($sformatf("v%0d stallreq", i),  32'(stallreq_o),        32'(vecs[i].e_sreq));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d id_pc", i),    id_pc_o,          vecs[i].e_pc);
      chk($sformatf("v%0d id_inst", i),  id_inst_o,        vecs[i].e_inst);
      chk($sformatf("v%0d id_valid", i), 32'(id_valid_o),  32'(vecs[i].e_val));
    end

    // randomized traffic
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      r_rst   = ($urandom_range(0, 99) == 0);
      r_stall = ($urandom_range(0, 9) < 3);
      r_ack   = ($urandom_range(0, 9) < 6);
      r_br    = ($urandom_range(0, 9) < 3) && !m_slot;
      r_tgt   = $urandom() & 32'hFFFF_FFFC;
      r_data  = $urandom();
      drive(r_rst, r_stall, r_ack, r_br, r_tgt, r_data);
      e_req = m_started && !m_held && !r_rst;
      #1;
      chk($sformatf("r%0d inst_req", c),  32'(mem_if.inst_req_o), 32'(e_req));
      chk($sformatf("r%0d inst_addr", c), mem_if.inst_addr_o,     m_pc);
      chk($sformatf("r%0d stallreq", c),  32'(stallreq_o),        32'(e_req && !r_ack));
      take = r_br && m_valid && !r_stall;
      @(posedge clk);
      if (r_rst) begin
        model_reset();
      end else begin
        loaded = 0; adv = 0;
        if (!m_started) begin
          m_started = 1;
        end else if (m_held) begin
          if (!r_stall) begin loaded = 1; adv = 1; m_id_inst = m_buf; end
        end else if (r_ack) begin
          if (!r_stall) begin loaded = 1; adv = 1; m_id_inst = r_data; end
          else begin m_held = 1; m_buf = r_data; end
        end else if (!r_stall) begin
          m_valid = 0; m_slot = 0; m_id_pc = m_pc; m_id_inst = 0;
        end
        if (take) m_armed = 1;
        if (loaded) begin
          m_valid = 1; m_id_pc = m_pc; m_slot = m_armed; m_armed = 0;
        end
        if (adv) begin
          m_pc   = take ? r_tgt : (m_pend ? m_pt : m_pc + 32'd4);
          m_pend = 0;
          m_held = 0;
        end else if (take) begin
          m_pend = 1; m_pt = r_tgt;
        end
      end
      exp_q.push_back({m_valid, m_id_pc, m_id_inst});
      #1;
      e = exp_q.pop_front();
      chk($sformatf("r%0d id_valid", c), 32'(id_valid_o), 32'(e[64]));
      chk($sformatf("r%0d id_pc", c),    id_pc_o,         e[63:32]);
      chk($sformatf("r%0d id_inst", c),  id_inst_o,       e[31:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decoder. Owns the PC, runs a request/acknowledge handshake with instruction memory, and drives the IF/ID pipeline register (PC, instruction, valid) that the decoder consumes. Applies the decoder's branch redirect after the delay-slot instruction, and holds or bubbles IF/ID under pipeline stall or memory wait.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset.
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-high.
- stall_i  in  1  pipeline controller holds IF and IF/ID this cycle.
- branch_flag_i  in  1  decoder's taken-branch/jump flag for the IF/ID instruction.
- branch_target_address_i  in  32  decoder's branch target.
- inst_req_o  out  1  instruction memory request.
- inst_addr_o  out  32  fetch address (= PC).
- inst_ack_i  in  1  memory completes the request this cycle.
- inst_rdata_i  in  32  instruction word, valid when inst_ack_i && inst_req_o.
- stallreq_o  out  1  IF waiting on memory (request pending, no ack).
- id_pc_o  out  32  IF/ID PC.
- id_inst_o  out  32  IF/ID instruction; 32'h0 (NOP) when bubble.
- id_valid_o  out  1  IF/ID holds a real instruction.

## Operation
- States: IDLE, REQ, HOLD.
- IDLE: entered on rst. inst_req_o=0. Goes to REQ next cycle unconditionally.
- REQ: inst_req_o=1, inst_addr_o=pc; address held stable until ack.
  - ack && !stall_i: IF/ID <= {pc, rdata, valid=1}; pc <= next_pc; stay REQ.
  - ack && stall_i: rdata into fetch buffer, IF/ID held; go HOLD.
  - !ack && !stall_i: IF/ID <= bubble {pc, 0, valid=0}; stallreq_o=1.
  - !ack && stall_i: IF/ID held; stallreq_o=1.
- HOLD: inst_req_o=0. When !stall_i: IF/ID <= {pc, buffer, 1}; pc <= next_pc; go REQ.
- Branch take event: take = branch_flag_i && id_valid_o && !stall_i (branch leaves ID).
- Delay slot: the instruction in flight at take is always executed.
- next_pc priority: take in same cycle → branch_target_address_i; else pend_valid → pend_target; else pc+4 (mod 2^32).
- take without a concurrent advance of IF: pend_valid <= 1, pend_target <= target.
- pend_valid is cleared when pc advances.
- branch_flag_i is ignored when id_valid_o=0.
- Width: all PC arithmetic is 32-bit, wrapping. Targets are not alignment-checked.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, inst_req_o=0, inst_addr_o=RESET_PC, stallreq_o=0, id_pc_o=0, id_inst_o=0, id_valid_o=0, pend_valid=0.
- First request is issued in the 2nd cycle after rst deasserts.
- Zero-wait memory (ack in the request cycle) gives one instruction per cycle: an instruction reaches ID one cycle after its ack.
- rst mid-request: the request is dropped in the same cycle. Memory ignores ack while inst_req_o=0. Any pending redirect is discarded.
- stallreq_o is combinational from state and inst_ack_i.

## Configuration
- IF_PERF_EN defined: adds perf_fetch_o (out, 32) and perf_stall_o (out, 32).
  - perf_fetch_o counts IF/ID loads with valid=1.
  - perf_stall_o counts cycles with stallreq_o=1.
  - Both reset to 0 and wrap at 2^32.
- IF_PERF_EN undefined: ports and counters are absent.

## Structure
- Shared defines file holds: IF state encodings, the bubble NOP constant (ZeroWord), InstAddrBus and InstBus widths, and RstEnable.
- Sub-module if_id: the IF/ID register with load, hold and bubble controls. The FSM and PC logic stay in if_stage.

## Test plan
- Reset, zero-wait memory returning addr as data → IF/ID receives pc 0,4,8 on consecutive cycles, starting 1 cycle after the first ack; id_inst_o equals the address.
- Ack delayed 3 cycles at pc=8 → 3 bubbles (valid=0, inst=0), stallreq_o high 3 cycles, then pc=8 valid.
- Branch at pc=0x10 with target 0x100, zero-wait → ID sequence 0x10, 0x14 (delay slot), 0x100.
- Same branch, delay-slot ack arrives 2 cycles after take → pend latched; next fetch after 0x14 is 0x100.
- stall_i held 2 cycles coinciding with an ack → HOLD, inst_req_o=0, IF/ID unchanged; on release the buffered word enters IF/ID and fetching resumes at pc+4.
- rst asserted while a request is pending with pend_valid=1 → next cycle all outputs at reset values; first request after release is to RESET_PC.
